// File: rtl/savemod_fifo_pkg.sv
// Shared constants and helpers for the enable/tag FIFO responder.
// Bit indices for the iEn, oTag and oErr fields.
package savemod_fifo_pkg;

   localparam int TAG_FULL  = 1;
   localparam int TAG_EMPTY = 0;
   localparam int EN_WR     = 1;
   localparam int EN_RD     = 0;
   localparam int ERR_OVF   = 1;
   localparam int ERR_UDF   = 0;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/savemod_fifo_responder_if.sv
// Enable/tag FIFO handshake bundle between initiator and responder.
// master = initiator side, slave = storage responder side.
interface savemod_fifo_if
   import savemod_fifo_pkg::*;
#(
   parameter int DW    = 4,
   parameter int DEPTH = 4
);
   localparam int AW = clog2(DEPTH);

   logic [1:0]    iEn;
   logic [DW-1:0] iData;
   logic [DW-1:0] oData;
   logic [1:0]    oTag;
   logic [AW:0]   oCount;
   logic [1:0]    oErr;

   modport master (
      output iEn, iData,
      input  oData, oTag, oCount, oErr
   );

   modport slave (
      input  iEn, iData,
      output oData, oTag, oCount, oErr
   );

endinterface

// File: rtl/savemod_fifo_ram.sv
// Simple dual-port DEPTH x DW storage array.
// Synchronous write, asynchronous read; contents are never reset.
module savemod_fifo_ram #(
   parameter int DW    = 4,
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clock,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/savemod_fifo_responder.sv
// Storage-side responder for the enable/tag FIFO handshake.
// Define SAVEMOD_FIFO_FWFT_EN for first-word-fall-through read data.
module savemod_fifo_responder
   import savemod_fifo_pkg::*;
#(
   parameter int DW    = 4,
   parameter int DEPTH = 4
) (
   input logic         clock,
   input logic         reset,
   savemod_fifo_if.slave bus
);

   localparam int AW = clog2(DEPTH);

   logic [AW:0]   wp_q, wp_d;
   logic [AW:0]   rp_q, rp_d;
   logic [AW:0]   count_q, count_d;
   logic [1:0]    tag_q, tag_d;
   logic [1:0]    err_q, err_d;
   logic [DW-1:0] rd_data;
   logic          full, empty;
   logic          wr_req, rd_req;
   logic          wr_acc, rd_acc;

   always_comb begin
      full    = (wp_q[AW] != rp_q[AW]) &&
                (wp_q[AW-1:0] == rp_q[AW-1:0]);
      empty   = (wp_q == rp_q);
      wr_req  = bus.iEn[EN_WR];
      rd_req  = bus.iEn[EN_RD];
      rd_acc  = rd_req && !empty;
      // a read on a full FIFO frees the slot the write lands in
      wr_acc  = wr_req && (!full || rd_acc);
      wp_d    = wp_q + {{AW{1'b0}}, wr_acc};
      rp_d    = rp_q + {{AW{1'b0}}, rd_acc};
      count_d = wp_d - rp_d;
      tag_d   = '0;
      tag_d[TAG_FULL]  = (wp_d[AW] != rp_d[AW]) &&
                         (wp_d[AW-1:0] == rp_d[AW-1:0]);
      tag_d[TAG_EMPTY] = (wp_d == rp_d);
      err_d   = err_q;
      if (wr_req && !wr_acc) err_d[ERR_OVF] = 1'b1;
      if (rd_req && !rd_acc) err_d[ERR_UDF] = 1'b1;
   end

   savemod_fifo_ram #(
      .DW    (DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clock (clock),
      .we    (wr_acc && reset),
      .waddr (wp_q[AW-1:0]),
      .wdata (bus.iData),
      .raddr (rp_q[AW-1:0]),
      .rdata (rd_data)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         tag_q   <= 2'b01;
         err_q   <= 2'b00;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         count_q <= count_d;
         tag_q   <= tag_d;
         err_q   <= err_d;
      end
   end

`ifdef SAVEMOD_FIFO_FWFT_EN
   logic [DW-1:0] hold_q, hold_d;

   // remember the last presented word so it stays visible when empty
   always_comb hold_d = empty ? hold_q : rd_data;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) hold_q <= '0;
      else        hold_q <= hold_d;
   end

   assign bus.oData = empty ? hold_q : rd_data;
`else
   logic [DW-1:0] data_q, data_d;

   always_comb data_d = rd_acc ? rd_data : data_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) data_q <= '0;
      else        data_q <= data_d;
   end

   assign bus.oData = data_q;
`endif

   assign bus.oTag   = tag_q;
   assign bus.oCount = count_q;
   assign bus.oErr   = err_q;

endmodule
